// File: rtl/uart_pkg.sv
// Shared types and constants for the UART MMIO device.
//   tx_state_t / rx_state_t : serial FSM states
//   UART_IDLE_LVL           : idle (mark) level of the serial line
//   CLK_DIV_DEFAULT         : default clock cycles per serial bit
package uart_pkg;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam logic UART_IDLE_LVL   = 1'b1;
   localparam int   CLK_DIV_DEFAULT = 16;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte queue used for both the TX and RX paths.
//   i_clk, i_rst      : clock, synchronous active-high reset (pointers/count only)
//   i_push, i_data    : enqueue request and byte
//   i_pop             : dequeue request (ignored when empty)
//   o_full, o_empty   : occupancy status
//   o_head            : byte at the queue head (meaningful only when not empty)
//   o_drop            : push refused this cycle because the queue stayed full
module uart_byte_fifo #(
   parameter int DEPTH_LOG = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic       o_full,
   output logic       o_empty,
   output logic [7:0] o_head,
   output logic       o_drop
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [7:0]           r_mem [DEPTH];
   logic [DEPTH_LOG-1:0] r_rd;
   logic [DEPTH_LOG-1:0] r_wr;
   logic [DEPTH_LOG:0]   r_cnt;
   logic                 w_pop;
   logic                 w_push;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (DEPTH_LOG+1)'(DEPTH));
   assign o_head  = r_mem[r_rd];

   // Pop is resolved first, so a push into a full queue succeeds when a
   // pop frees a slot in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);
   assign o_drop = i_push & ~w_push;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop)  r_rd <= r_rd + DEPTH_LOG'(1);
         if (w_push) r_wr <= r_wr + DEPTH_LOG'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (DEPTH_LOG+1)'(1);
            2'b01:   r_cnt <= r_cnt - (DEPTH_LOG+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/uart_mmio_device.sv
// Device-side endpoint of the CPU's byte UART MMIO port: queues CPU writes
// and sends them 8N1 on uart_tx; receives 8N1 on uart_rx into a queue read
// through uart_ready/uart_rdata and popped by uart_consumed.
//   clk, rst                 : clock, synchronous active-high reset
//   uart_we, uart_wdata      : push a byte into the TX queue
//   uart_consumed            : pop the RX queue head
//   uart_ready, uart_rdata   : RX queue non-empty / head byte (00 when empty)
//   uart_tx, uart_rx         : serial lines, idle high
//   tx_busy                  : TX queue non-empty or frame in progress
//   tx_overrun, rx_overrun   : sticky queue-full drop flags
//   rx_frame_err             : sticky stop-bit-low flag
// Build option: define UART_LOOPBACK_EN to feed the internal TX line into the
// receiver; uart_tx is then held high and uart_rx is ignored.
module uart_mmio_device
   import uart_pkg::*;
#(
   parameter int CLK_DIV      = CLK_DIV_DEFAULT,
   parameter int TX_DEPTH_LOG = 3,
   parameter int RX_DEPTH_LOG = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_we,
   input  logic [7:0] uart_wdata,
   input  logic       uart_consumed,
   output logic       uart_ready,
   output logic [7:0] uart_rdata,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       tx_busy,
   output logic       tx_overrun,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int            CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

   // ---------------- transmit path ----------------
   tx_state_t     r_tx_st;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_bit;
   logic [7:0]    r_tx_sh;
   logic          r_tx_line;
   logic          w_tx_full, w_tx_empty, w_tx_drop, w_tx_pop, w_tx_bit_end;
   logic [7:0]    w_tx_head;

   uart_byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
      .i_clk(clk), .i_rst(rst), .i_push(uart_we), .i_data(uart_wdata),
      .i_pop(w_tx_pop), .o_full(w_tx_full), .o_empty(w_tx_empty),
      .o_head(w_tx_head), .o_drop(w_tx_drop)
   );

   assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
   // A new byte is taken when idle, or at the end of a stop bit so frames
   // run back-to-back without an idle gap.
   assign w_tx_pop = ~w_tx_empty &
                     ((r_tx_st == TX_IDLE) | ((r_tx_st == TX_STOP) & w_tx_bit_end));
   assign tx_busy  = ~w_tx_empty | (r_tx_st != TX_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_st   <= TX_IDLE;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
         r_tx_line <= UART_IDLE_LVL;
      end else if (w_tx_pop) begin
         r_tx_sh   <= w_tx_head;
         r_tx_line <= 1'b0;
         r_tx_cnt  <= '0;
         r_tx_st   <= TX_START;
      end else begin
         r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CW'(1);
         case (r_tx_st)
            TX_START: if (w_tx_bit_end) begin
               r_tx_line <= r_tx_sh[0];
               r_tx_sh   <= r_tx_sh >> 1;
               r_tx_bit  <= '0;
               r_tx_st   <= TX_DATA;
            end
            TX_DATA: if (w_tx_bit_end) begin
               if (r_tx_bit == 3'd7) begin
                  r_tx_line <= UART_IDLE_LVL;
                  r_tx_st   <= TX_STOP;
               end else begin
                  r_tx_line <= r_tx_sh[0];
                  r_tx_sh   <= r_tx_sh >> 1;
                  r_tx_bit  <= r_tx_bit + 3'd1;
               end
            end
            TX_STOP: if (w_tx_bit_end) r_tx_st <= TX_IDLE;
            default: begin
               r_tx_cnt  <= '0;
               r_tx_line <= UART_IDLE_LVL;
            end
         endcase
      end
   end

   // ---------------- line routing ----------------
   logic w_rx_in;
`ifdef UART_LOOPBACK_EN
   assign uart_tx = UART_IDLE_LVL;
   assign w_rx_in = r_tx_line;
`else
   assign uart_tx = r_tx_line;
   assign w_rx_in = uart_rx;
`endif

   // ---------------- receive path ----------------
   rx_state_t     r_rx_st;
   logic [CW-1:0] r_rx_cnt;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_sh;
   logic          r_rx_s1, r_rx_s2;
   logic          w_rx_bit_end, w_rx_push, w_rx_ferr;
   logic          w_rx_full, w_rx_empty, w_rx_drop;
   logic [7:0]    w_rx_head;

   assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);
   assign w_rx_push    = (r_rx_st == RX_STOP) & w_rx_bit_end & r_rx_s2;
   assign w_rx_ferr    = (r_rx_st == RX_STOP) & w_rx_bit_end & ~r_rx_s2;

   uart_byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
      .i_clk(clk), .i_rst(rst), .i_push(w_rx_push), .i_data(r_rx_sh),
      .i_pop(uart_consumed), .o_full(w_rx_full), .o_empty(w_rx_empty),
      .o_head(w_rx_head), .o_drop(w_rx_drop)
   );

   assign uart_ready = ~w_rx_empty;
   assign uart_rdata = uart_ready ? w_rx_head : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1  <= UART_IDLE_LVL;
         r_rx_s2  <= UART_IDLE_LVL;
         r_rx_st  <= RX_IDLE;
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
      end else begin
         r_rx_s1 <= w_rx_in;
         r_rx_s2 <= r_rx_s1;
         case (r_rx_st)
            RX_IDLE: begin
               r_rx_cnt <= '0;
               if (!r_rx_s2) r_rx_st <= RX_START;
            end
            // Half a bit after the falling edge: still low means a real start
            // bit, and every later sample lands mid-bit.
            RX_START: if (r_rx_cnt == HALF_LAST) begin
               r_rx_cnt <= '0;
               r_rx_bit <= '0;
               r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
               r_rx_cnt <= r_rx_cnt + CW'(1);
            end
            RX_DATA: if (w_rx_bit_end) begin
               r_rx_cnt <= '0;
               r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
               if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
               else                  r_rx_bit <= r_rx_bit + 3'd1;
            end else begin
               r_rx_cnt <= r_rx_cnt + CW'(1);
            end
            default: if (w_rx_bit_end) begin
               r_rx_cnt <= '0;
               r_rx_st  <= RX_IDLE;
            end else begin
               r_rx_cnt <= r_rx_cnt + CW'(1);
            end
         endcase
      end
   end

   // ---------------- sticky status ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_overrun   <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (w_tx_drop) tx_overrun   <= 1'b1;
         if (w_rx_drop) rx_overrun   <= 1'b1;
         if (w_rx_ferr) rx_frame_err <= 1'b1;
      end
   end

endmodule
